// File: rtl/regfile_pkg.sv
// regfile_pkg: op encodings and default sizes shared by the register file and decode
package regfile_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CPYIN  = 3'd1;
  localparam logic [2:0] OP_CPYOUT = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_ALUWR  = 3'd4;
  localparam logic [2:0] OP_SWAP   = 3'd5;
  localparam logic [2:0] OP_PUSH   = 3'd6;
  localparam logic [2:0] OP_POP    = 3'd7;
endpackage

// File: rtl/res_stack.sv
// res_stack: LIFO shadow stack for the accumulator with overflow/underflow events
module res_stack #(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 4,
  localparam int CW = $clog2(STACK_DEPTH + 1),
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf_evt,
  output logic             unf_evt
);
  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [CW-1:0] top;
  assign full = count == CW'(STACK_DEPTH);
  assign empty = count == '0;
  assign top = count - CW'(1);
  assign dout = empty ? '0 : mem[top[AW-1:0]];
  assign ovf_evt = push & full;
  assign unf_evt = pop & empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[count[AW-1:0]] <= din;
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= top;
    end
  end
endmodule

// File: rtl/accum_regfile_p.sv
// accum_regfile_p: general registers plus accumulator res with a shadow stack and sticky errors
module accum_regfile_p
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int SELW = $clog2(NREGS),
  parameter int CONE_IDX = NREGS - 2,
  parameter int CTWO_IDX = NREGS - 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             reg_write,
  input  logic [2:0]                       op,
  input  logic [SELW-1:0]                  reg_sel,
  input  logic [WIDTH-1:0]                 write_data,
  input  logic                             err_clr,
  output logic [WIDTH-1:0]                 reg_val,
  output logic [WIDTH-1:0]                 res_val,
  output logic [WIDTH-1:0]                 cone_reg,
  output logic [WIDTH-1:0]                 ctwo_reg,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_empty,
  output logic                             stack_full,
  output logic                             err_ovf,
  output logic                             err_unf
);
  if (CONE_IDX >= NREGS || CTWO_IDX >= NREGS || NREGS < 2 || (1 << SELW) != NREGS || STACK_DEPTH < 1)
    begin : g_bad_params
      $error("accum_regfile_p: illegal parameter combination");
    end
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] res, res_d, wr_data, stk_dout;
  logic push, pop, wr, ovf_evt, unf_evt;
  assign push = reg_write && op == OP_PUSH;
  assign pop = reg_write && op == OP_POP;
  assign wr = reg_write && (op == OP_CPYOUT || op == OP_LOAD || op == OP_SWAP);
  assign wr_data = op == OP_LOAD ? write_data : res;
  assign reg_val = regs[reg_sel];
  assign res_val = res;
  assign cone_reg = regs[CONE_IDX];
  assign ctwo_reg = regs[CTWO_IDX];
  // SWAP reads regs[reg_sel] and res before the edge, so both halves see pre-edge values
  always_comb
    res_d = !reg_write ? res :
            (op == OP_CPYIN || op == OP_SWAP) ? regs[reg_sel] :
            op == OP_ALUWR ? write_data :
            (op == OP_POP && !stack_empty) ? stk_dout : res;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      res <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wr) regs[reg_sel] <= wr_data;
      res <= res_d;
      err_ovf <= ovf_evt | (err_ovf & ~err_clr);
      err_unf <= unf_evt | (err_unf & ~err_clr);
    end
  end
  res_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(res),
    .dout(stk_dout),
    .count(stack_count),
    .full(stack_full),
    .empty(stack_empty),
    .ovf_evt(ovf_evt),
    .unf_evt(unf_evt)
  );
endmodule

// File: tb/tb_accum_regfile_p.sv
// tb_accum_regfile_p: default and wide/shallow instances checked against a behavioural model
module tb_accum_regfile_p;
  import regfile_pkg::*;
  logic clk = 0, rst = 1, rw = 0, clr = 0;
  logic [2:0] op = 0;
  logic [3:0] sel = 0;
  logic [31:0] wd = 0;
  logic [15:0] r0_reg, r0_res, r0_cone, r0_ctwo;
  logic [2:0] r0_cnt;
  logic r0_emp, r0_full, r0_ovf, r0_unf;
  logic [31:0] r1_reg, r1_res, r1_cone, r1_ctwo;
  logic [0:0] r1_cnt;
  logic r1_emp, r1_full, r1_ovf, r1_unf;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  accum_regfile_p u0 (
    .clk(clk), .reset(rst), .reg_write(rw), .op(op), .reg_sel(sel[2:0]),
    .write_data(wd[15:0]), .err_clr(clr), .reg_val(r0_reg), .res_val(r0_res),
    .cone_reg(r0_cone), .ctwo_reg(r0_ctwo), .stack_count(r0_cnt),
    .stack_empty(r0_emp), .stack_full(r0_full), .err_ovf(r0_ovf), .err_unf(r0_unf)
  );
  accum_regfile_p #(.WIDTH(32), .NREGS(16), .STACK_DEPTH(1)) u1 (
    .clk(clk), .reset(rst), .reg_write(rw), .op(op), .reg_sel(sel),
    .write_data(wd), .err_clr(clr), .reg_val(r1_reg), .res_val(r1_res),
    .cone_reg(r1_cone), .ctwo_reg(r1_ctwo), .stack_count(r1_cnt),
    .stack_empty(r1_emp), .stack_full(r1_full), .err_ovf(r1_ovf), .err_unf(r1_unf)
  );

  logic [31:0] m_regs [2][16];
  logic [31:0] m_res [2];
  logic [31:0] m_stk [2][4];
  int m_cnt [2];
  bit m_ovf [2], m_unf [2];
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instance 0 is 16-bit/8 regs/depth 4, instance 1 is 32-bit/16 regs/depth 1
  int mn, md, ms;
  logic [31:0] mmsk, mdat, mtmp;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mn = i ? 16 : 8;
      md = i ? 1 : 4;
      mmsk = i ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      ms = int'(sel) % mn;
      mdat = wd & mmsk;
      if (rst) begin
        for (int k = 0; k < 16; k++) m_regs[i][k] = 0;
        m_res[i] = 0;
        m_cnt[i] = 0;
        m_ovf[i] = 0;
        m_unf[i] = 0;
        started = 1;
      end else begin
        m_ovf[i] = (rw && op == OP_PUSH && m_cnt[i] == md) || (m_ovf[i] && !clr);
        m_unf[i] = (rw && op == OP_POP && m_cnt[i] == 0) || (m_unf[i] && !clr);
        if (rw) begin
          if (op == OP_CPYIN) m_res[i] = m_regs[i][ms];
          else if (op == OP_CPYOUT) m_regs[i][ms] = m_res[i];
          else if (op == OP_LOAD) m_regs[i][ms] = mdat;
          else if (op == OP_ALUWR) m_res[i] = mdat;
          else if (op == OP_SWAP) begin
            mtmp = m_regs[i][ms];
            m_regs[i][ms] = m_res[i];
            m_res[i] = mtmp;
          end else if (op == OP_PUSH && m_cnt[i] < md) begin
            m_stk[i][m_cnt[i]] = m_res[i];
            m_cnt[i]++;
          end else if (op == OP_POP && m_cnt[i] > 0) begin
            m_cnt[i]--;
            m_res[i] = m_stk[i][m_cnt[i]];
          end
        end
      end
    end
  end

  task automatic cmp(input int i, input logic [31:0] a_reg, a_res, a_cone, a_ctwo,
                     input int a_cnt, input logic a_emp, a_full, a_ovf, a_unf);
    int n, d;
    n = i ? 16 : 8;
    d = i ? 1 : 4;
    chk($sformatf("i%0d reg_val", i), a_reg, m_regs[i][int'(sel) % n]);
    chk($sformatf("i%0d res_val", i), a_res, m_res[i]);
    chk($sformatf("i%0d cone_reg", i), a_cone, m_regs[i][n-2]);
    chk($sformatf("i%0d ctwo_reg", i), a_ctwo, m_regs[i][n-1]);
    chk($sformatf("i%0d stack_count", i), a_cnt, m_cnt[i]);
    chk($sformatf("i%0d stack_empty", i), 32'(a_emp), 32'(m_cnt[i] == 0));
    chk($sformatf("i%0d stack_full", i), 32'(a_full), 32'(m_cnt[i] == d));
    chk($sformatf("i%0d err_ovf", i), 32'(a_ovf), 32'(m_ovf[i]));
    chk($sformatf("i%0d err_unf", i), 32'(a_unf), 32'(m_unf[i]));
  endtask

  always @(negedge clk) if (started) begin
    cmp(0, 32'(r0_reg), 32'(r0_res), 32'(r0_cone), 32'(r0_ctwo), int'(r0_cnt),
        r0_emp, r0_full, r0_ovf, r0_unf);
    cmp(1, r1_reg, r1_res, r1_cone, r1_ctwo, int'(r1_cnt), r1_emp, r1_full, r1_ovf, r1_unf);
  end

  task automatic cyc(input bit r, input bit w, input logic [2:0] o, input logic [3:0] s,
                     input logic [31:0] d, input bit c);
    rst = r; rw = w; op = o; sel = s; wd = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, OP_NOP, 0, 0, 0);
    chk("rst res", 32'(r0_res), 0);
    chk("rst empty", 32'(r0_emp), 1);
    chk("rst full", 32'(r0_full), 0);
    cyc(0, 1, OP_LOAD, 3, 32'h1234, 0);
    cyc(0, 1, OP_CPYIN, 3, 0, 0);
    chk("cpyin res", 32'(r0_res), 32'h1234);
    chk("cpyin reg3", 32'(r0_reg), 32'h1234);
    cyc(0, 1, OP_ALUWR, 0, 32'h00AA, 0);
    cyc(0, 1, OP_LOAD, 5, 32'h5555, 0);
    cyc(0, 1, OP_SWAP, 5, 0, 0);
    chk("swap res", 32'(r0_res), 32'h5555);
    chk("swap reg5", 32'(r0_reg), 32'h00AA);
    for (int v = 1; v <= 4; v++) begin
      cyc(0, 1, OP_ALUWR, 0, 32'(v), 0);
      cyc(0, 1, OP_PUSH, 0, 0, 0);
    end
    chk("push full", 32'(r0_full), 1);
    chk("push count", 32'(r0_cnt), 4);
    cyc(0, 1, OP_PUSH, 0, 0, 0);
    chk("ovf flag", 32'(r0_ovf), 1);
    chk("ovf count", 32'(r0_cnt), 4);
    for (int v = 4; v >= 1; v--) begin
      cyc(0, 1, OP_POP, 0, 0, 0);
      chk($sformatf("pop %0d", v), 32'(r0_res), 32'(v));
    end
    chk("pop empty", 32'(r0_emp), 1);
    cyc(0, 1, OP_ALUWR, 0, 32'h0F0F, 0);
    cyc(0, 1, OP_POP, 0, 0, 0);
    chk("unf flag", 32'(r0_unf), 1);
    chk("unf res", 32'(r0_res), 32'h0F0F);
    cyc(0, 1, OP_POP, 0, 0, 1);
    chk("unf set wins", 32'(r0_unf), 1);
    cyc(0, 1, OP_NOP, 0, 0, 1);
    chk("unf cleared", 32'(r0_unf), 0);
    chk("ovf cleared", 32'(r0_ovf), 0);
    cyc(0, 0, OP_LOAD, 6, 32'hFFFF, 0);
    chk("rw0 cone", 32'(r0_cone), 0);
    chk("ctwo before", 32'(r0_ctwo), 0);
    cyc(0, 1, OP_LOAD, 7, 32'hBEEF, 0);
    chk("ctwo after", 32'(r0_ctwo), 32'hBEEF);
    cyc(0, 1, OP_PUSH, 0, 0, 0);
    cyc(0, 1, OP_PUSH, 0, 0, 0);
    chk("count 2", 32'(r0_cnt), 2);
    cyc(1, 1, OP_PUSH, 0, 0, 0);
    chk("rst+push count", 32'(r0_cnt), 0);
    chk("rst+push res", 32'(r0_res), 0);
    chk("rst+push ctwo", 32'(r0_ctwo), 0);
    chk("rst+push ovf", 32'(r0_ovf), 0);
    chk("rst+push unf", 32'(r0_unf), 0);
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(63) == 0, $urandom_range(7) != 0, 3'($urandom), 4'($urandom),
          $urandom, $urandom_range(7) == 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/accum_regfile_p.md
Name: accum_regfile_p

Overview:
- Parametrised successor to the fixed 8×16 accumulator register file.
- Holds NREGS general registers plus one accumulator `res`, and adds a LIFO shadow stack for saving and restoring `res` (nested subroutines and loops).
- Sits between decode/ALU/memory and the datapath. Supplies the selected-register value, the accumulator value and two fixed compare registers to the ALU/branch unit.
- Adds synchronous reset, a SWAP op and a sticky error reporting path.

Parameters:
- WIDTH, 16, data width of every register, `res` and the stack.
- NREGS, 8, number of general registers; must be a power of 2 and ≥ 2.
- SELW, $clog2(NREGS), width of reg_sel.
- CONE_IDX, NREGS-2, register index driven onto cone_reg.
- CTWO_IDX, NREGS-1, register index driven onto ctwo_reg.
- STACK_DEPTH, 4, number of shadow-stack entries; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_write  in  1  global write enable; when 0 the op is ignored (treated as NOP).
- op  in  3  operation code; see Behaviour.
- reg_sel  in  SELW  selects the general register.
- write_data  in  WIDTH  data from the ALU or memory.
- err_clr  in  1  clears the sticky error flags.
- reg_val  out  WIDTH  combinational read of reg[reg_sel].
- res_val  out  WIDTH  current `res`.
- cone_reg  out  WIDTH  reg[CONE_IDX].
- ctwo_reg  out  WIDTH  reg[CTWO_IDX].
- stack_count  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_empty  out  1  stack_count == 0.
- stack_full  out  1  stack_count == STACK_DEPTH.
- err_ovf  out  1  sticky: a push was attempted while the stack was full.
- err_unf  out  1  sticky: a pop was attempted while the stack was empty.

Behaviour:
- Reset (synchronous, highest priority):
  - All registers, `res` and stack contents are set to 0.
  - stack_count is set to 0.
  - err_ovf and err_unf are set to 0.
  - After reset, stack_empty = 1 and stack_full = 0.
- Reads are combinational and show pre-edge state; there is no write-to-read bypass.
  - A write at edge N is visible on the outputs after edge N.
- Op encoding (evaluated only when reg_write = 1):
  - 000 NOP: no state change.
  - 001 CPYIN: `res` ← reg[reg_sel].
  - 010 CPYOUT: reg[reg_sel] ← `res`.
  - 011 LOAD: reg[reg_sel] ← write_data.
  - 100 ALUWR: `res` ← write_data.
  - 101 SWAP: `res` ← reg[reg_sel] and reg[reg_sel] ← `res`, in the same edge, using pre-edge values.
  - 110 PUSH: stack[count] ← `res`; count increments; `res` is unchanged.
  - 111 POP: `res` ← stack[count-1]; count decrements.
- Exactly one op per cycle, so there are no priority conflicts between ops.
- PUSH when full:
  - Stack contents and count are unchanged.
  - err_ovf is set.
  - `res` is unchanged.
- POP when empty:
  - `res` and count are unchanged.
  - err_unf is set.
- err_clr clears both sticky flags at the edge.
  - If err_clr coincides with a new error event, the set wins (the flag stays 1).
- reg_write = 0: no state changes, including the error flags. err_clr still takes effect.
- Reset asserted mid-sequence (e.g. with a PUSH on the same edge): reset wins and the op is discarded.
- stack_full and stack_empty are decoded combinationally from the registered count.
- Latency for every write: 1 cycle.
- No arithmetic is performed on data; all values are stored at full WIDTH.
- Elaboration-time checks: CONE_IDX and CTWO_IDX must be < NREGS. Violation is an elaboration error.

Decomposition:
- Shared package `regfile_pkg`:
  - op localparams OP_NOP, OP_CPYIN, OP_CPYOUT, OP_LOAD, OP_ALUWR, OP_SWAP, OP_PUSH, OP_POP.
  - Default WIDTH and NREGS constants, shared with decode.
- One sub-module, `res_stack`, parametrised by WIDTH and STACK_DEPTH.
  - Inputs: push, pop, din.
  - Outputs: dout, count, full, empty, ovf_evt, unf_evt.
- The top level holds the register array, `res`, op decode and the sticky flags.

Test Plan:
- Reset, then LOAD reg3 ← 0x1234, then CPYIN sel = 3 → res_val = 0x1234 one edge later; reg_val reads 0x1234 with sel = 3.
- ALUWR 0x00AA, LOAD reg5 ← 0x5555, SWAP sel = 5 → res_val = 0x5555 and reg5 = 0x00AA after a single edge.
- PUSH res values 1, 2, 3, 4 (DEPTH = 4) → stack_full = 1 and count = 4. A fifth PUSH → err_ovf = 1 and count stays 4. Then POP ×4 → res_val = 4, 3, 2, 1 in order, and stack_empty = 1.
- POP on an empty stack with res = 0x0F0F → err_unf = 1 and res stays 0x0F0F. Then err_clr with a simultaneous empty POP → err_unf stays 1. Then err_clr alone → err_unf = 0.
- reg_write = 0 with op = LOAD, sel = 6, data 0xFFFF → reg6/cone_reg unchanged. LOAD reg7 ← 0xBEEF with reg_write = 1 → ctwo_reg = 0xBEEF after the edge, not before.
- Reset asserted on the same edge as PUSH with count = 2 → count = 0, res = 0, all registers 0, error flags 0. Also rerun the scenarios with WIDTH = 32, NREGS = 16 and STACK_DEPTH = 1.
